npc_fetch: RTL and testbench
============================

Name: npc_fetch

Overview:
- Consumer side of the next-PC select code `NPCOp`, which the branch/jump resolver produces.
- Holds the architectural PC and computes the next PC from `NPCOp`, immediate and register target.
- Runs a request/acknowledge fetch handshake with instruction memory.
- Presents one fetched instruction at a time to decode/control; multicycle, single outstanding fetch.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, redirect target on misaligned register jump (only with NPC_ALIGN_CHECK_EN).

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous, active-low reset.
- NPCOp  in  2  next-PC select: NPC_PLUS4, NPC_BRANCH, NPC_JUMP_IMM, NPC_JUMP_REG.
- Imm  in  26  instruction immediate field; branch uses [15:0], jump uses [25:0].
- RegTarget  in  32  register value for NPC_JUMP_REG.
- resolve  in  1  control has finished the held instruction; NPCOp/Imm/RegTarget valid this cycle.
- stall  in  1  blocks PC update while held.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, equal to PC.
- imem_ack  in  1  fetch data valid, single-cycle pulse.
- imem_rdata  in  32  fetched instruction.
- pc_out  out  32  PC of the held instruction.
- pc_plus4  out  32  pc_out+4, for link writes.
- instr_out  out  32  held instruction.
- instr_valid  out  1  instr_out is valid.
- align_fault  out  1  one-cycle pulse on a misaligned register jump (feature only; tied 0 otherwise).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rstn). All state is cleared on rstn low regardless of clk.
- Reset values: PC=RESET_PC, state=FETCH, instr_out=0, instr_valid=0, align_fault=0.
- States:
  - FETCH: imem_req=1 and imem_addr=PC (both combinational from state/PC). Hold until imem_ack. On ack, latch imem_rdata into instr_out, set instr_valid=1 next cycle, go to HELD.
  - HELD: imem_req=0. If resolve=1 and stall=0: PC<=npc, instr_valid<=0, go to FETCH. Otherwise hold all state. stall=1 wins over resolve, and control must keep resolve asserted until accepted.
- npc (32-bit, modulo 2^32, so 0xFFFF_FFFC+4 wraps to 0):
  - PLUS4 = PC+4.
  - BRANCH = PC+4 + (sign_extend(Imm[15:0])<<2).
  - JUMP_IMM = {pc_plus4[31:28], Imm[25:0], 2'b00}.
  - JUMP_REG = RegTarget, unmodified.
- Latency:
  - First imem_req in the cycle rstn deasserts.
  - ack in cycle N -> instr_valid=1 in N+1.
  - accepted resolve in cycle M -> imem_req with the new address in M+1.
- Boundary cases:
  - resolve or stall while in FETCH: ignored.
  - imem_ack while in HELD: ignored, nothing latched.
  - rstn asserted mid-fetch: request dropped immediately; instruction memory must also discard its outstanding response.
- Encodings (shared): NPC_PLUS4=2'b00, NPC_BRANCH=2'b01, NPC_JUMP_IMM=2'b10, NPC_JUMP_REG=2'b11.

Optional Feature:
- Macro: NPC_ALIGN_CHECK_EN.
- When defined, in HELD on an accepted NPC_JUMP_REG with RegTarget[1:0]!=0:
  - PC<=EXC_VECTOR instead of RegTarget.
  - align_fault pulses 1 for exactly that cycle.
- When undefined: no check, RegTarget is loaded as-is, align_fault is constant 0.

Decomposition:
- Shared include ctrl_encode_def.v: NPC_* encodings, RESET_PC default, EXC_VECTOR default.
- State encoding (FETCH/HELD) stays local.
- One natural sub-module, npc_calc: purely combinational npc from PC, NPCOp, Imm and RegTarget, including the alignment check.
- npc_fetch keeps the FSM and registers.

Test Plan:
- Reset release, ack 2 cycles later with rdata=32'h2408_0005 -> imem_addr=0x3000 from cycle 0; instr_valid=1, instr_out=0x2408_0005, pc_out=0x3000 one cycle after ack.
- HELD at PC 0x3000, resolve with PLUS4 -> next imem_addr=0x3004; repeat with BRANCH Imm[15:0]=16'hFFFE -> 0x3000.
- HELD at 0x3010, JUMP_IMM Imm=26'h0000C40 -> 0x3100; JUMP_REG RegTarget=0x0000_3400 -> 0x3400.
- resolve with stall=1 for 3 cycles, then stall=0 -> PC unchanged and imem_req=0 during stall; update on the first unstalled cycle; spurious ack during HELD leaves instr_out unchanged.
- PC=0xFFFF_FFFC, PLUS4 -> 0x0000_0000; rstn pulsed low mid-FETCH -> imem_req drops asynchronously, PC=0x3000 after release.
- With NPC_ALIGN_CHECK_EN: JUMP_REG RegTarget=0x3402 -> PC=0x4180 and align_fault high for 1 cycle; without it -> PC=0x3402 and align_fault=0.

Source files
------------

// File: rtl/npc_fetch_pkg.sv
// rtl/npc_fetch_pkg.sv - shared next-PC select encodings, PC defaults and offset helper
package npc_fetch_pkg;

  // Next-PC select codes produced by the branch/jump resolver
  localparam logic [1:0] NPC_PLUS4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH   = 2'b01;
  localparam logic [1:0] NPC_JUMP_IMM = 2'b10;
  localparam logic [1:0] NPC_JUMP_REG = 2'b11;

  // Default PC after reset and default redirect for a misaligned register jump
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_4180;

  // Sign-extended 16-bit branch offset, converted from words to bytes
  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/npc_fetch_npc_calc.sv
// rtl/npc_fetch_npc_calc.sv - combinational next-PC select, alignment check under NPC_ALIGN_CHECK_EN
module npc_calc
  import npc_fetch_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic [31:0] pc,
  input  logic [1:0]  NPCOp,
  input  logic [25:0] Imm,
  input  logic [31:0] RegTarget,
  output logic [31:0] npc,
  output logic [31:0] pc_plus4,
  output logic        misaligned
);

  logic [31:0] base_npc;

  assign pc_plus4 = pc + 32'd4;

`ifdef NPC_ALIGN_CHECK_EN
  // A register jump to a non-word address is redirected to the exception vector
  assign misaligned = (NPCOp == NPC_JUMP_REG) && (RegTarget[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Select the architectural next PC; all arithmetic wraps modulo 2^32
  always_comb begin
    base_npc = pc_plus4;
    case (NPCOp)
      NPC_PLUS4:    base_npc = pc_plus4;
      NPC_BRANCH:   base_npc = pc_plus4 + branch_offset(Imm[15:0]);
      NPC_JUMP_IMM: base_npc = {pc_plus4[31:28], Imm, 2'b00};
      NPC_JUMP_REG: base_npc = RegTarget;
      default:      base_npc = pc_plus4;
    endcase
  end

  assign npc = misaligned ? EXC_VECTOR : base_npc;

endmodule

// File: rtl/npc_fetch.sv
// rtl/npc_fetch.sv - PC register and single-outstanding fetch FSM (align check via NPC_ALIGN_CHECK_EN)
module npc_fetch
  import npc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  NPCOp,
  input  logic [25:0] Imm,
  input  logic [31:0] RegTarget,
  input  logic        resolve,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        align_fault
);

  localparam logic [0:0] ST_FETCH = 1'b0;
  localparam logic [0:0] ST_HELD  = 1'b1;

  logic [0:0]  state;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic        fault_q;
  logic [31:0] npc;
  logic        misaligned;
  logic        accept;

  npc_calc #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_npc_calc (
    .pc         (pc_q),
    .NPCOp      (NPCOp),
    .Imm        (Imm),
    .RegTarget  (RegTarget),
    .npc        (npc),
    .pc_plus4   (pc_plus4),
    .misaligned (misaligned)
  );

  // stall overrides resolve; resolve only matters while an instruction is held
  assign accept = (state == ST_HELD) && resolve && !stall;

  // Request is gated by rstn so it drops the instant reset asserts, not at the next edge
  assign imem_req    = rstn && (state == ST_FETCH);
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign align_fault = fault_q;

  // FSM and architectural state: latch on ack in FETCH, redirect PC on accepted resolve in HELD
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      case (state)
        ST_FETCH: begin
          if (imem_ack) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            state   <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (accept) begin
            pc_q    <= npc;
            valid_q <= 1'b0;
            fault_q <= misaligned;
            state   <= ST_FETCH;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_npc_fetch.sv
// tb/tb_npc_fetch.sv - directed and randomized self-checking bench for npc_fetch
module tb_npc_fetch;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [1:0]  npcop = 2'b00;
  logic [25:0] imm = 26'h0;
  logic [31:0] regtarget = 32'h0;
  logic        resolve = 1'b0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        align_fault;

  int ncomp = 0;
  int nfail = 0;

  logic [31:0] pc_m;
  logic [31:0] held_m;
  bit          align_en;

  always #5 clk = ~clk;

  npc_fetch dut (
    .clk         (clk),
    .rstn        (rstn),
    .NPCOp       (npcop),
    .Imm         (imm),
    .RegTarget   (regtarget),
    .resolve     (resolve),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .align_fault (align_fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural next-PC rule written from the ISA description
  function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [1:0] op,
                                            input logic [25:0] im, input logic [31:0] rt);
    logic [31:0] seq;
    int          off;
    seq = pc + 32'd4;
    off = $signed(im[15:0]);
    case (op)
      2'd0: return seq;
      2'd1: return seq + 32'(off * 4);
      2'd2: return {seq[31:28], 4'h0} * 0 + (seq & 32'hF000_0000) + {4'h0, im, 2'b00};
      default: begin
        if (align_en && (rt % 4 != 0)) return 32'h0000_4180;
        return rt;
      end
    endcase
  endfunction

  function automatic bit model_fault(input logic [1:0] op, input logic [31:0] rt);
    return align_en && (op == 2'd3) && (rt % 4 != 0);
  endfunction

  // Serve one fetch after 'delay' idle cycles, with ignored resolve/stall noise meanwhile
  task automatic do_fetch(input logic [31:0] data, input int delay);
    for (int i = 0; i < delay; i++) begin
      check("fetch_req", {31'h0, imem_req}, 32'h1);
      check("fetch_addr", imem_addr, pc_m);
      resolve = 1'($urandom);
      stall   = 1'($urandom);
      npcop   = 2'($urandom);
      tick();
    end
    check("fetch_req", {31'h0, imem_req}, 32'h1);
    check("fetch_addr", imem_addr, pc_m);
    resolve    = 1'b0;
    stall      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    held_m     = data;
    check("held_valid", {31'h0, instr_valid}, 32'h1);
    check("held_instr", instr_out, held_m);
    check("held_pc", pc_out, pc_m);
    check("held_pc_plus4", pc_plus4, pc_m + 32'd4);
    check("held_req", {31'h0, imem_req}, 32'h0);
    check("held_fault", {31'h0, align_fault}, 32'h0);
  endtask

  // Present a resolve, stalled for 'stalls' cycles (optionally with spurious acks), then accept
  task automatic do_resolve(input logic [1:0] op, input logic [25:0] im, input logic [31:0] rt,
                            input int stalls, input bit spurious);
    npcop     = op;
    imm       = im;
    regtarget = rt;
    resolve   = 1'b1;
    for (int s = 0; s < stalls; s++) begin
      stall      = 1'b1;
      imem_ack   = spurious;
      imem_rdata = $urandom;
      tick();
      imem_ack = 1'b0;
      check("stall_req", {31'h0, imem_req}, 32'h0);
      check("stall_pc", pc_out, pc_m);
      check("stall_instr", instr_out, held_m);
      check("stall_valid", {31'h0, instr_valid}, 32'h1);
    end
    stall = 1'b0;
    tick();
    resolve = 1'b0;
    pc_m = model_npc(pc_m, op, im, rt);
    check("npc_req", {31'h0, imem_req}, 32'h1);
    check("npc_addr", imem_addr, pc_m);
    check("npc_valid", {31'h0, instr_valid}, 32'h0);
    check("npc_fault", {31'h0, align_fault}, {31'h0, model_fault(op, rt)});
  endtask

  initial begin
`ifdef NPC_ALIGN_CHECK_EN
    align_en = 1'b1;
`else
    align_en = 1'b0;
`endif
    pc_m   = 32'h0000_3000;
    held_m = 32'h0;

    // Reset state
    #12;
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_instr", instr_out, 32'h0);
    check("rst_pc", pc_out, 32'h0000_3000);
    check("rst_fault", {31'h0, align_fault}, 32'h0);

    // Release: request appears in the same cycle
    @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    check("rel_req", {31'h0, imem_req}, 32'h1);
    check("rel_addr", imem_addr, 32'h0000_3000);
    do_fetch(32'h2408_0005, 2);
    check("first_instr", instr_out, 32'h2408_0005);

    // Directed next-PC cases
    do_resolve(2'd0, 26'h0, 32'h0, 0, 1'b0);
    check("plus4_addr", imem_addr, 32'h0000_3004);
    do_fetch(32'h1111_0001, 1);
    do_resolve(2'd1, 26'h000_FFFE, 32'h0, 0, 1'b0);
    check("branch_back_addr", imem_addr, 32'h0000_3000);
    do_fetch(32'h1111_0002, 0);
    do_resolve(2'd3, 26'h0, 32'h0000_3010, 0, 1'b0);
    do_fetch(32'h1111_0003, 1);
    do_resolve(2'd2, 26'h000_0C40, 32'h0, 0, 1'b0);
    check("jimm_addr", imem_addr, 32'h0000_3100);
    do_fetch(32'h1111_0004, 0);
    do_resolve(2'd3, 26'h0, 32'h0000_3400, 0, 1'b0);
    check("jreg_addr", imem_addr, 32'h0000_3400);

    // Stall holds for three cycles, spurious acks ignored
    do_fetch(32'h1111_0005, 1);
    do_resolve(2'd0, 26'h0, 32'h0, 3, 1'b1);
    check("stall_release_addr", imem_addr, 32'h0000_3404);

    // Wrap-around
    do_fetch(32'h1111_0006, 0);
    do_resolve(2'd3, 26'h0, 32'hFFFF_FFFC, 0, 1'b0);
    do_fetch(32'h1111_0007, 0);
    do_resolve(2'd0, 26'h0, 32'h0, 0, 1'b0);
    check("wrap_addr", imem_addr, 32'h0000_0000);

    // Misaligned register jump
    do_fetch(32'h1111_0008, 0);
    do_resolve(2'd3, 26'h0, 32'h0000_3402, 0, 1'b0);
    check("align_addr", imem_addr, align_en ? 32'h0000_4180 : 32'h0000_3402);
    tick();
    check("align_fault_once", {31'h0, align_fault}, 32'h0);
    do_fetch(32'h1111_0009, 1);

    // Randomized instruction stream
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  op;
      logic [25:0] im;
      logic [31:0] rt;
      op = 2'($urandom);
      im = 26'($urandom);
      rt = $urandom;
      if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
      do_resolve(op, im, rt, $urandom_range(0, 3), 1'($urandom));
      do_fetch($urandom, $urandom_range(0, 3));
    end

    // Asynchronous reset in the middle of a fetch
    do_resolve(2'd0, 26'h0, 32'h0, 0, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    check("async_req_drop", {31'h0, imem_req}, 32'h0);
    check("async_valid", {31'h0, instr_valid}, 32'h0);
    check("async_pc", pc_out, 32'h0000_3000);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    pc_m = 32'h0000_3000;
    #1;
    check("rerel_req", {31'h0, imem_req}, 32'h1);
    check("rerel_addr", imem_addr, 32'h0000_3000);
    do_fetch(32'h2222_0001, 1);
    do_resolve(2'd1, 26'h000_0003, 32'h0, 1, 1'b0);
    check("post_reset_branch", imem_addr, 32'h0000_3010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
